// File: rtl/user_data_chk_if.sv
// Aurora RX user AXI-Stream bundle (no tready: every valid beat is consumed).
//   master : drives tdata/tkeep/tlast/tvalid (Aurora core RX side)
//   slave  : receives them (checker side)
interface user_data_chk_if;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned KEEP_W = DATA_W / 8;

    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tlast;
    logic              tvalid;

    modport master (output tdata, output tkeep, output tlast, output tvalid);
    modport slave  (input  tdata, input  tkeep, input  tlast, input  tvalid);
endinterface

// File: rtl/user_data_chk.sv
// Receive-side checker for the Aurora user AXI-Stream loopback pattern.
// Each frame must be P_FRAME_LEN beats carrying 0..P_FRAME_LEN-1, tkeep all ones,
// tlast on the final beat. Reports per-beat/per-frame errors, keeps statistics
// and raises o_link_ok after P_LOCK_FRAMES consecutive clean frames.
// Ports:
//   i_clk, i_rst (async, active-high), i_clr (sync statistics clear)
//   s_axi_rx        : RX AXI-Stream slave (tdata/tkeep/tlast/tvalid)
//   o_data_err      : pulse, beat data/keep mismatch
//   o_len_err       : pulse, frame too short or too long
//   o_frame_done    : pulse, tlast beat consumed; o_frame_bad qualifies it
//   o_good_cnt      : clean frames (wraps)
//   o_bad_cnt       : bad frames (saturating)
//   o_word_err_cnt  : mismatched beats (saturating)
//   o_link_ok       : level, lock reached since last error/clear
module user_data_chk #(
    parameter int unsigned P_FRAME_LEN   = 100,
    parameter int unsigned P_LOCK_FRAMES = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clr,
    user_data_chk_if.slave        s_axi_rx,
    output logic                  o_data_err,
    output logic                  o_len_err,
    output logic                  o_frame_done,
    output logic                  o_frame_bad,
    output logic [31:0]           o_good_cnt,
    output logic [15:0]           o_bad_cnt,
    output logic [15:0]           o_word_err_cnt,
    output logic                  o_link_ok
);
    localparam int unsigned IDX_W  = 16;
    localparam int unsigned LOCK_W = 8;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(P_FRAME_LEN - 1);
    localparam logic [LOCK_W-1:0] LOCK_N   = LOCK_W'(P_LOCK_FRAMES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_DROP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              frame_bad_q, frame_bad_d;
    logic              data_err_q, data_err_d;
    logic              len_err_q, len_err_d;
    logic              done_q, done_d;
    logic              done_bad_q, done_bad_d;
    logic [31:0]       good_q, good_d;
    logic [15:0]       bad_q, bad_d;
    logic [15:0]       werr_q, werr_d;
    logic [LOCK_W-1:0] consec_q, consec_d;
    logic              link_q, link_d;

    logic beat_chk;
    logic at_last;
    logic data_mis;
    logic len_mis;
    logic frame_end;
    logic bad_now;

    // Beat classification; idx_q is 0 whenever the FSM is in S_IDLE.
    always_comb begin
        beat_chk  = s_axi_rx.tvalid && (state_q != S_DROP);
        at_last   = (idx_q == LAST_IDX);
        data_mis  = beat_chk && ((s_axi_rx.tdata != {16'd0, idx_q}) || (s_axi_rx.tkeep != 4'hF));
        len_mis   = beat_chk && (s_axi_rx.tlast ? !at_last : at_last);
        frame_end = s_axi_rx.tvalid && s_axi_rx.tlast;
        bad_now   = frame_bad_q || data_mis || len_mis;
    end

    // Next-state, pulses and statistics.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        frame_bad_d = frame_bad_q;
        data_err_d  = data_mis;
        len_err_d   = len_mis;
        done_d      = frame_end;
        done_bad_d  = frame_end && bad_now;
        good_d      = good_q;
        bad_d       = bad_q;
        werr_d      = werr_q;
        consec_d    = consec_q;
        link_d      = link_q;

        if (s_axi_rx.tvalid) begin
            if (s_axi_rx.tlast) begin
                state_d = S_IDLE;
                idx_d   = '0;
            end else if (state_q != S_DROP) begin
                // A missing tlast on the last index diverts the rest of the frame to S_DROP
                if (at_last) begin
                    state_d = S_DROP;
                end else begin
                    state_d = S_RECV;
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            frame_bad_d = frame_end ? 1'b0 : bad_now;
        end

        if (data_mis && (werr_q != 16'hFFFF)) begin
            werr_d = werr_q + 16'd1;
        end
        if (data_mis || len_mis) begin
            link_d = 1'b0;
        end

        if (frame_end) begin
            if (bad_now) begin
                if (bad_q != 16'hFFFF) begin
                    bad_d = bad_q + 16'd1;
                end
                consec_d = '0;
                link_d   = 1'b0;
            end else begin
                good_d = good_q + 32'd1;
                if (consec_q < LOCK_N) begin
                    consec_d = consec_q + LOCK_W'(1);
                end
                if (consec_d == LOCK_N) begin
                    link_d = 1'b1;
                end
            end
        end

        // Statistics clear overrides any same-cycle update
        if (i_clr) begin
            good_d   = '0;
            bad_d    = '0;
            werr_d   = '0;
            consec_d = '0;
            link_d   = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            frame_bad_q <= 1'b0;
            data_err_q  <= 1'b0;
            len_err_q   <= 1'b0;
            done_q      <= 1'b0;
            done_bad_q  <= 1'b0;
            good_q      <= '0;
            bad_q       <= '0;
            werr_q      <= '0;
            consec_q    <= '0;
            link_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            frame_bad_q <= frame_bad_d;
            data_err_q  <= data_err_d;
            len_err_q   <= len_err_d;
            done_q      <= done_d;
            done_bad_q  <= done_bad_d;
            good_q      <= good_d;
            bad_q       <= bad_d;
            werr_q      <= werr_d;
            consec_q    <= consec_d;
            link_q      <= link_d;
        end
    end

    assign o_data_err     = data_err_q;
    assign o_len_err      = len_err_q;
    assign o_frame_done   = done_q;
    assign o_frame_bad    = done_bad_q;
    assign o_good_cnt     = good_q;
    assign o_bad_cnt      = bad_q;
    assign o_word_err_cnt = werr_q;
    assign o_link_ok      = link_q;

endmodule

// File: tb/tb_user_data_chk.sv
// Directed bench for user_data_chk: frames are driven on the falling edge and
// outputs are sampled on the following falling edge, so each beat's pulses are
// observed in the tick that consumed it.
module tb_user_data_chk;
    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        data_err, len_err, frame_done, frame_bad, link_ok;
    logic [31:0] good_cnt;
    logic [15:0] bad_cnt, werr_cnt;

    always #5 clk = ~clk;

    user_data_chk_if rx();

    user_data_chk #(.P_FRAME_LEN(100), .P_LOCK_FRAMES(4)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_clr          (clr),
        .s_axi_rx       (rx),
        .o_data_err     (data_err),
        .o_len_err      (len_err),
        .o_frame_done   (frame_done),
        .o_frame_bad    (frame_bad),
        .o_good_cnt     (good_cnt),
        .o_bad_cnt      (bad_cnt),
        .o_word_err_cnt (werr_cnt),
        .o_link_ok      (link_ok)
    );

    int   vectors = 0;
    int   miscompares = 0;
    int   n_de, n_le, n_done, n_dbad;
    int   cur_beat, de_at, le_at;
    logic link_at_de, link_at_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_tally();
        n_de = 0; n_le = 0; n_done = 0; n_dbad = 0;
        de_at = -1; le_at = -1;
        link_at_de = 1'bx; link_at_done = 1'bx;
    endtask

    // One clock; record pulses seen for the beat just consumed.
    task automatic tick();
        @(negedge clk);
        if (data_err) begin
            n_de++; de_at = cur_beat; link_at_de = link_ok;
        end
        if (len_err) begin
            n_le++; le_at = cur_beat;
        end
        if (frame_done) begin
            n_done++;
            if (frame_bad) n_dbad++;
            link_at_done = link_ok;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic beat(input int idx, input logic [31:0] d, input logic [3:0] k, input logic l);
        rx.tvalid = 1'b1; rx.tdata = d; rx.tkeep = k; rx.tlast = l;
        cur_beat = idx;
        tick();
        rx.tvalid = 1'b0; rx.tlast = 1'b0; rx.tkeep = 4'h0; rx.tdata = 32'h0;
        cur_beat = -1;
    endtask

    // n beats of the counting pattern, tlast on beat n-1; optional corrupted beat.
    task automatic frame(input int n, input int bad_i, input logic [31:0] bad_d,
                         input logic [3:0] bad_k, input bit gaps, input bit clr_last);
        logic [31:0] d;
        logic [3:0]  k;
        for (int i = 0; i < n; i++) begin
            if (gaps) idle(int'($urandom_range(0, 2)));
            d = 32'(i); k = 4'hF;
            if (i == bad_i) begin d = bad_d; k = bad_k; end
            if (clr_last && i == n - 1) clr = 1'b1;
            beat(i, d, k, i == n - 1);
            clr = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0;
        rx.tvalid = 1'b0; rx.tdata = 32'h0; rx.tkeep = 4'h0; rx.tlast = 1'b0;
        cur_beat = -1;
        clear_tally();
        idle(3);
        rst = 1'b0;
        idle(2);
        check("reset_good", good_cnt, 32'd0);
        check("reset_bad", 32'(bad_cnt), 32'd0);
        check("reset_werr", 32'(werr_cnt), 32'd0);
        check("reset_flags", {28'd0, data_err, len_err, frame_done, link_ok}, 32'd0);

        // Two clean frames with gaps
        clear_tally();
        frame(100, -1, 32'h0, 4'hF, 1'b1, 1'b0);
        frame(100, -1, 32'h0, 4'hF, 1'b1, 1'b0);
        idle(2);
        check("clean2_done", 32'(n_done), 32'd2);
        check("clean2_done_bad", 32'(n_dbad), 32'd0);
        check("clean2_good", good_cnt, 32'd2);
        check("clean2_bad", 32'(bad_cnt), 32'd0);
        check("clean2_link", {31'd0, link_ok}, 32'd0);

        // Frames 3 and 4 (back-to-back): lock on the 4th done pulse
        frame(100, -1, 32'h0, 4'hF, 1'b0, 1'b0);
        check("lock_3rd_link", {31'd0, link_at_done}, 32'd0);
        frame(100, -1, 32'h0, 4'hF, 1'b0, 1'b0);
        check("lock_4th_link", {31'd0, link_at_done}, 32'd1);
        check("lock_good", good_cnt, 32'd4);

        // Beat 37 corrupted to 0xDEAD
        clear_tally();
        frame(100, 37, 32'h0000_DEAD, 4'hF, 1'b0, 1'b0);
        idle(1);
        check("dead_n_de", 32'(n_de), 32'd1);
        check("dead_de_at", 32'(de_at), 32'd37);
        check("dead_link_at_de", {31'd0, link_at_de}, 32'd0);
        check("dead_n_le", 32'(n_le), 32'd0);
        check("dead_werr", 32'(werr_cnt), 32'd1);
        check("dead_bad", 32'(bad_cnt), 32'd1);
        check("dead_done_bad", 32'(n_dbad), 32'd1);

        // Short frame: tlast on index 49
        clear_tally();
        frame(50, -1, 32'h0, 4'hF, 1'b0, 1'b0);
        idle(1);
        check("short_n_le", 32'(n_le), 32'd1);
        check("short_le_at", 32'(le_at), 32'd49);
        check("short_n_de", 32'(n_de), 32'd0);
        check("short_bad", 32'(bad_cnt), 32'd2);
        frame(100, -1, 32'h0, 4'hF, 1'b0, 1'b0);
        check("after_short_good", good_cnt, 32'd5);

        // Long frame: 150 beats, tlast on 149
        clear_tally();
        frame(150, -1, 32'h0, 4'hF, 1'b1, 1'b0);
        idle(1);
        check("long_n_le", 32'(n_le), 32'd1);
        check("long_le_at", 32'(le_at), 32'd99);
        check("long_n_de", 32'(n_de), 32'd0);
        check("long_n_done", 32'(n_done), 32'd1);
        check("long_done_bad", 32'(n_dbad), 32'd1);
        check("long_bad", 32'(bad_cnt), 32'd3);

        // Reset at beat 60, then a clean frame
        clear_tally();
        for (int i = 0; i < 60; i++) beat(i, 32'(i), 4'hF, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("midrst_good", good_cnt, 32'd0);
        check("midrst_bad", 32'(bad_cnt), 32'd0);
        frame(100, -1, 32'h0, 4'hF, 1'b0, 1'b0);
        check("midrst_clean_good", good_cnt, 32'd1);
        check("midrst_clean_done", {16'(n_done), 16'(n_dbad)}, {16'd1, 16'd0});
        clear_tally();
        frame(100, 5, 32'd5, 4'h7, 1'b0, 1'b0);
        check("keep7_n_de", 32'(n_de), 32'd1);
        check("keep7_de_at", 32'(de_at), 32'd5);
        check("keep7_werr", 32'(werr_cnt), 32'd1);

        // Lock again, then clear on the tlast beat of a clean frame
        for (int f = 0; f < 4; f++) frame(100, -1, 32'h0, 4'hF, 1'b0, 1'b0);
        check("relock_link", {31'd0, link_ok}, 32'd1);
        clear_tally();
        frame(100, -1, 32'h0, 4'hF, 1'b0, 1'b1);
        idle(1);
        check("clr_good", good_cnt, 32'd0);
        check("clr_bad", 32'(bad_cnt), 32'd0);
        check("clr_werr", 32'(werr_cnt), 32'd0);
        check("clr_link", {31'd0, link_ok}, 32'd0);
        check("clr_done", 32'(n_done), 32'd1);
        frame(100, -1, 32'h0, 4'hF, 1'b0, 1'b0);
        check("after_clr_good", good_cnt, 32'd1);

        // 65540 single-beat errored frames: counters saturate
        clear_tally();
        for (int i = 0; i < 65540; i++) beat(0, 32'hFFFF_FFFF, 4'hF, 1'b1);
        idle(1);
        check("sat_werr", 32'(werr_cnt), 32'h0000_FFFF);
        check("sat_bad", 32'(bad_cnt), 32'h0000_FFFF);
        check("sat_n_de", 32'(n_de), 32'd65540);
        check("sat_n_le", 32'(n_le), 32'd65540);
        check("sat_good", good_cnt, 32'd1);
        check("sat_link", {31'd0, link_ok}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
